// File: rtl/layer_seq_ctrl_if.sv
// Bundle of the data, configuration and status signals of layer_seq_ctrl.
//
// Handshake: a transfer happens on a rising clk edge where both valid and
// ready of the same channel are 1. The producer holds data stable while
// valid is 1 and ready is 0. The consumer may raise or lower ready at any
// time. This applies to the in_* channel (the block consumes) and to the
// out_* channel (the block produces).
interface layer_seq_ctrl_if #(
    parameter int NEURONS  = 4,
    parameter int FAN_IN   = 6,
    parameter int OUT_BITS = 2
);
    localparam int IDX_W = $clog2(NEURONS);

    logic [NEURONS*FAN_IN-1:0]   in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [NEURONS*OUT_BITS-1:0] out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        cfg_we;
    logic [IDX_W+FAN_IN-1:0]     cfg_addr;
    logic [OUT_BITS-1:0]         cfg_data;
    logic                        busy;
    logic                        cfg_err;
    logic [1:0]                  dbg_state;

    modport master (
        output in_data, in_valid, out_ready, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_data, out_valid, busy, cfg_err, dbg_state
    );

    modport slave (
        input  in_data, in_valid, out_ready, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_data, out_valid, busy, cfg_err, dbg_state
    );
endinterface

// File: rtl/layer_seq_ctrl.sv
// Time-multiplexed LUT neuron layer: one input vector is latched, then one
// neuron per cycle looks up its truth table, and the assembled result is
// offered on the output channel. Truth tables are writable only while idle.
module layer_seq_ctrl #(
    parameter int NEURONS  = 4,
    parameter int FAN_IN   = 6,
    parameter int OUT_BITS = 2
) (
    input logic             clk,
    input logic             rst,
    layer_seq_ctrl_if.slave bus
);
    localparam int IDX_W  = $clog2(NEURONS);
    localparam int ADDR_W = IDX_W + FAN_IN;
    localparam int DEPTH  = NEURONS * (2 ** FAN_IN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURONS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state;
    logic [IDX_W-1:0]            idx;
    logic [NEURONS*FAN_IN-1:0]   in_lat;
    logic [NEURONS*OUT_BITS-1:0] out_data_r;
    logic                        out_valid_r;
    logic                        in_ready_r;
    logic                        busy_r;
    logic                        cfg_err_r;

    logic [OUT_BITS-1:0]         lut [DEPTH];
    logic [ADDR_W-1:0]           lut_addr;
    logic [OUT_BITS-1:0]         lut_out;
    logic                        cfg_write;

    // Table lookup for the neuron currently being evaluated.
    always_comb begin
        lut_addr = {idx, in_lat[idx*FAN_IN +: FAN_IN]};
        lut_out  = lut[lut_addr];
    end

    // Writes only land while idle so a running evaluation sees a fixed table.
    assign cfg_write = bus.cfg_we && (state == IDLE);

    // Truth-table storage, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                lut[i] <= '0;
            end
        end else if (cfg_write) begin
            lut[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    // Sequencer: accept a vector, evaluate one neuron per cycle, hold the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            in_lat      <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            if (bus.cfg_we && (state != IDLE)) begin
                cfg_err_r <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_lat     <= bus.in_data;
                        idx        <= '0;
                        state      <= EVAL;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                EVAL: begin
                    out_data_r[idx*OUT_BITS +: OUT_BITS] <= lut_out;
                    idx <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.cfg_err   = cfg_err_r;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Directed test of layer_seq_ctrl with the default 4 x 6-in x 2-out geometry.
module tb_layer_seq_ctrl;
    localparam int NEURONS  = 4;
    localparam int FAN_IN   = 6;
    localparam int OUT_BITS = 2;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    layer_seq_ctrl_if #(.NEURONS(NEURONS), .FAN_IN(FAN_IN), .OUT_BITS(OUT_BITS)) bus ();

    layer_seq_ctrl #(.NEURONS(NEURONS), .FAN_IN(FAN_IN), .OUT_BITS(OUT_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
    endtask

    initial begin
        logic [7:0] held;
        int         t_valid [3];
        int         cyc;
        int         got;
        n_assert = 0;
        n_fail   = 0;
        idle_inputs();

        // Reset
        rst = 1'b1;
        step();
        step();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 8'h00);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_cfg_err", bus.cfg_err, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        rst = 1'b0;
        step();
        chk("idle_in_ready", bus.in_ready, 1'b1);

        // Empty tables: all-ones vector gives zero result after 4 cycles
        bus.in_data  = '1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("acc_in_ready", bus.in_ready, 1'b0);
        chk("acc_busy", bus.busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("lat_out_valid_low", bus.out_valid, 1'b0);
            step();
        end
        chk("lat_out_valid_low", bus.out_valid, 1'b0);
        step();
        chk("t1_out_valid", bus.out_valid, 1'b1);
        chk("t1_out_data", bus.out_data, 8'h00);
        chk("t1_cfg_err", bus.cfg_err, 1'b0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("t1_consumed", bus.out_valid, 1'b0);
        chk("t1_in_ready", bus.in_ready, 1'b1);

        // Program two entries, then evaluate
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = {2'd0, 6'b100000};
        bus.cfg_data = 2'b11;
        step();
        bus.cfg_addr = {2'd3, 6'b000100};
        bus.cfg_data = 2'b10;
        step();
        bus.cfg_we   = 1'b0;
        bus.in_data  = {6'b000100, 6'd0, 6'd0, 6'b100000};
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = 24'h5a3c96;
        for (int i = 0; i < 4; i++) step();
        chk("t2_out_valid", bus.out_valid, 1'b1);
        chk("t2_out_data", bus.out_data, 8'b10_00_00_11);

        // Output stall for 10 cycles
        held = 8'b10_00_00_11;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_out_valid", bus.out_valid, 1'b1);
            chk("stall_out_data", bus.out_data, held);
            chk("stall_in_ready", bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("stall_release_in_ready", bus.in_ready, 1'b1);
        chk("stall_release_valid", bus.out_valid, 1'b0);
        chk("idle_hold_out_data", bus.out_data, held);

        // Config write during EVAL is dropped and flagged
        bus.in_data  = '0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = {2'd1, 6'd0};
        bus.cfg_data = 2'b01;
        step();
        bus.cfg_we = 1'b0;
        chk("eval_cfg_err", bus.cfg_err, 1'b1);
        for (int i = 0; i < 3; i++) step();
        chk("t4_out_valid", bus.out_valid, 1'b1);
        chk("t4_out_data", bus.out_data, 8'h00);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("t4_cfg_err_sticky", bus.cfg_err, 1'b1);

        // Same-edge config write and accept
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = {2'd2, 6'b000110};
        bus.cfg_data = 2'b01;
        bus.in_data  = {6'b000100, 6'b000110, 6'd0, 6'b100000};
        bus.in_valid = 1'b1;
        step();
        bus.cfg_we   = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("t5_out_valid", bus.out_valid, 1'b1);
        chk("t5_out_data", bus.out_data, 8'b10_01_00_11);
        chk("t5_cfg_err_sticky", bus.cfg_err, 1'b1);
        bus.out_ready = 1'b1;
        step();

        // Back-to-back with both handshakes tied high
        bus.in_valid = 1'b1;
        cyc = 0;
        got = 0;
        while (got < 3 && cyc < 40) begin
            step();
            cyc++;
            if (bus.out_valid) begin
                t_valid[got] = cyc;
                chk("b2b_out_data", bus.out_data, 8'b10_01_00_11);
                got++;
            end
        end
        chk("b2b_count", got, 3);
        if (got == 3) begin
            chk("b2b_gap0", t_valid[1] - t_valid[0], NEURONS + 2);
            chk("b2b_gap1", t_valid[2] - t_valid[1], NEURONS + 2);
        end

        // Drain to idle, then reset in the middle of an evaluation
        bus.in_valid = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 20) begin
            step();
            cyc++;
        end
        chk("drain_busy", bus.busy, 1'b0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk("mid_rst_out_data", bus.out_data, 8'h00);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_cfg_err", bus.cfg_err, 1'b0);
        chk("mid_rst_in_ready", bus.in_ready, 1'b1);
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("post_rst_out_valid", bus.out_valid, 1'b0);
            chk("post_rst_out_data", bus.out_data, 8'h00);
        end

        // Tables were cleared by reset
        bus.in_data  = {6'b000100, 6'b000110, 6'd0, 6'b100000};
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("clr_out_valid", bus.out_valid, 1'b1);
        chk("clr_out_data", bus.out_data, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
